// File: rtl/iot_sequencer_if.sv
// iot_sequencer_if: IOT request/response bus between CPU timing chain, sequencer and device selectors
// Ports (master = CPU side, slave = sequencer):
//   start, mb[11:0], abort            request and cancel from the CPU
//   io_skip, io_ac_clear              bus-level responses from the selected device
//   busy, dev_code[5:0], cpu_iot      sequence status and latched device select
//   iop1, iop2, iop4                  IOP pulses
//   skip, ac_clear, done              sticky responses and completion strobe
interface iot_sequencer_if;
  logic        start;
  logic [11:0] mb;
  logic        abort;
  logic        io_skip;
  logic        io_ac_clear;
  logic        busy;
  logic [5:0]  dev_code;
  logic        cpu_iot;
  logic        iop1;
  logic        iop2;
  logic        iop4;
  logic        skip;
  logic        ac_clear;
  logic        done;
  modport master (
    output start, mb, abort, io_skip, io_ac_clear,
    input  busy, dev_code, cpu_iot, iop1, iop2, iop4, skip, ac_clear, done
  );
  modport slave (
    input  start, mb, abort, io_skip, io_ac_clear,
    output busy, dev_code, cpu_iot, iop1, iop2, iop4, skip, ac_clear, done
  );
endinterface

// File: rtl/iot_sequencer.sv
// iot_sequencer: sequences a PDP-8/I IOT instruction into IOP1/IOP2/IOP4 bus pulses
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    iot_sequencer_if.slave; start/mb/abort/io_skip/io_ac_clear in,
//          busy/dev_code/cpu_iot/iop1/iop2/iop4/skip/ac_clear/done out (all registered)
// Parameters: PULSE_LEN cycles per IOP slot, GAP_LEN dead cycles after each slot (1..255)
module iot_sequencer #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2
) (
  input logic            clk,
  input logic            rst_n,
  iot_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, P1, G1, P2, G2, P4, G4, DONE} state_t;
  localparam logic [7:0] PL = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GL = 8'(GAP_LEN - 1);
  state_t     state, nxt;
  logic [7:0] cnt, cnt_n, reload;
  logic [2:0] op, op_n;
  logic       accept, expired, cpu_n, iop_any;
  always_comb begin
    accept  = state == IDLE && bus.start && bus.mb[11:9] == 3'o6;
    expired = cnt == 8'd0;
    nxt     = state;
    if (state != IDLE && bus.abort)
      nxt = IDLE;
    else
      case (state)
        IDLE: nxt = accept ? P1 : IDLE;
        P1:   nxt = expired ? G1 : P1;
        G1:   nxt = expired ? P2 : G1;
        P2:   nxt = expired ? G2 : P2;
        G2:   nxt = expired ? P4 : G2;
        P4:   nxt = expired ? G4 : P4;
        G4:   nxt = expired ? DONE : G4;
        DONE: nxt = IDLE;
      endcase
    // Every state entry reloads the counter with that state's length minus one
    reload  = (nxt == P1 || nxt == P2 || nxt == P4) ? PL :
              (nxt == G1 || nxt == G2 || nxt == G4) ? GL : 8'd0;
    cnt_n   = (nxt != state) ? reload : expired ? 8'd0 : cnt - 8'd1;
    op_n    = accept ? bus.mb[2:0] : op;
    cpu_n   = accept ? bus.mb[8:3] == 6'd0 : bus.cpu_iot;
    // Responses are sampled only while a registered IOP output is high
    iop_any = bus.iop1 | bus.iop2 | bus.iop4;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      op           <= 3'd0;
      bus.busy     <= 1'b0;
      bus.dev_code <= 6'd0;
      bus.cpu_iot  <= 1'b0;
      bus.iop1     <= 1'b0;
      bus.iop2     <= 1'b0;
      bus.iop4     <= 1'b0;
      bus.skip     <= 1'b0;
      bus.ac_clear <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      state        <= nxt;
      cnt          <= cnt_n;
      op           <= op_n;
      bus.busy     <= nxt != IDLE;
      bus.dev_code <= accept ? bus.mb[8:3] : bus.dev_code;
      bus.cpu_iot  <= cpu_n;
      bus.iop1     <= nxt == P1 && op_n[0] && !cpu_n;
      bus.iop2     <= nxt == P2 && op_n[1] && !cpu_n;
      bus.iop4     <= nxt == P4 && op_n[2] && !cpu_n;
      bus.skip     <= accept ? 1'b0 : bus.skip | (iop_any & bus.io_skip);
      bus.ac_clear <= accept ? 1'b0 : bus.ac_clear | (iop_any & bus.io_ac_clear);
      bus.done     <= nxt == DONE;
    end
endmodule

// File: doc/iot_sequencer.md
# iot_sequencer

Sequences a PDP-8/I IOT instruction onto the I/O bus. It accepts an instruction word from the processor's major-state logic, latches the 6-bit device code for the device selectors, and emits the IOP1, IOP2 and IOP4 pulses in fixed-timing slots. It also collects the skip and AC-clear responses from the selected device. It sits between the CPU timing chain and the bank of device-selector modules.

## Interface
Parameters:
- PULSE_LEN, 4, cycles each IOP slot lasts (1..255)
- GAP_LEN, 2, dead cycles after each IOP slot (1..255)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to execute the instruction on mb
- mb  in  12  instruction word; bits [11:9] opcode, [8:3] device code, [2:0] IOP bits
- abort  in  1  synchronous cancel of an in-progress sequence
- io_skip  in  1  device skip request (bus level)
- io_ac_clear  in  1  device AC-clear request (bus level)
- busy  out  1  sequence in progress
- dev_code  out  6  latched device code, driven to device-selector inputs
- cpu_iot  out  1  latched flag: device code 00 (processor-internal IOT)
- iop1, iop2, iop4  out  1 each  IOP pulses, active high
- skip  out  1  sticky: skip requested during this IOT
- ac_clear  out  1  sticky: AC clear requested during this IOT
- done  out  1  one-cycle completion strobe

## Operation
- All outputs are registered.
- States: IDLE, P1, G1, P2, G2, P4, G4, DONE.
- IDLE:
  - start=1 and mb[11:9]=3'o6: latch dev_code=mb[8:3], op=mb[2:0], cpu_iot=(mb[8:3]==0).
  - Clear skip and ac_clear, then go to P1.
  - start with any other opcode is ignored.
- P1/P2/P4 each last PULSE_LEN cycles. G1/G2/G4 each last GAP_LEN cycles. An 8-bit down-counter is reloaded on every state entry.
- iop1 is high for all of P1 only if op[0]=1 and cpu_iot=0. iop2 uses P2 and op[1]; iop4 uses P4 and op[2].
- An unselected slot still elapses. Timing is fixed regardless of op bits.
- cpu_iot=1: all IOP outputs stay low and the slots still elapse. The CPU decodes these internally.
- Any cycle in which an IOP output is high samples the responses:
  - io_skip=1 sets skip.
  - io_ac_clear=1 sets ac_clear.
  - Once set, each flag holds until the next accepted start or until reset.
  - Responses are ignored during gaps and in IDLE.
- After G4, go to DONE: done=1 for one cycle, busy still 1. Then return to IDLE.
- dev_code and cpu_iot hold their value in IDLE until the next accepted start.
- start while busy=1 is ignored; no queueing.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and iop1/2/4 fall on the next edge.
  - done is not pulsed; skip and ac_clear keep their current values.
  - abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Asynchronous reset (rst_n=0), including mid-sequence: state=IDLE, all outputs 0, dev_code=0, counter=0.

## Timing
- Reference point: start accepted at clock edge k.
- busy is high from cycle k+1 through the DONE cycle.
- P=PULSE_LEN, G=GAP_LEN. Slot windows:
  - iop1 window: cycles k+1 .. k+P.
  - iop2 window: cycles k+1+(P+G) .. k+P+(P+G).
  - iop4 window: cycles k+1+2(P+G) .. k+P+2(P+G).
- done: cycle k+1+3(P+G). busy falls in the following cycle. Total busy length is 3(P+G)+1 cycles (19 at defaults).
- skip and ac_clear are visible the cycle after the sampled cycle.
- Earliest next accept: the start edge at the end of the first IDLE cycle after DONE.
- No combinational path from any input to any output.

## Test plan
- Reset, then 6031 at defaults -> dev_code=03; iop1 high cycles k+1..k+4; iop2 and iop4 never high; done at k+19; busy low at k+20.
- 6417 with io_skip high only during the third iop4 cycle -> all three IOPs pulse; skip=1 from the next cycle through the following accepted start; ac_clear=0.
- Non-IOT start (mb=7200), then start while busy -> no busy, no iop, no done.
- 6002 (device 00) -> cpu_iot=1; iop2 stays low; done still at k+19.
- 6557, abort asserted in the second P2 cycle -> iop2 drops on the next edge; busy=0 one cycle after abort; done never pulses.
- PULSE_LEN=1, GAP_LEN=1, 6207 back-to-back starts, with rst_n pulsed low mid-P4 of the second -> each IOP is exactly 1 cycle wide; done at k+7 for the first; all outputs 0 immediately on rst_n low.
